// File: rtl/instr_mem_arbiter_pkg.sv
// Shared types for the instruction RAM arbiter: requester tags, response pipeline
// payload and the RAM word-address width helper.
package instr_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_F    = 2'd1,
    TAG_D    = 2'd2
  } tag_e;

  // Owner and error status of the read that returns next cycle
  typedef struct packed {
    tag_e tag;
    logic err;
  } rsp_pipe_t;

  function automatic int unsigned mem_aw(input int unsigned mem_size);
    return $clog2(mem_size);
  endfunction

endpackage

// File: rtl/instr_mem_arbiter_if.sv
// Requester and RAM-side signals of the instruction RAM arbiter.
// The slave modport is the arbiter; the master modport is the surrounding logic.
interface instr_mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_AW     = 9
);
  logic                  p_valid;
  logic                  p_ready;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [DATA_WIDTH-1:0] p_wdata;
  logic                  f_valid;
  logic                  f_ready;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_flush;
  logic                  f_rsp_valid;
  logic [DATA_WIDTH-1:0] f_rsp_data;
  logic                  d_valid;
  logic                  d_ready;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic                  d_rsp_valid;
  logic [DATA_WIDTH-1:0] d_rsp_data;
  logic                  d_rsp_err;
  logic                  mem_en;
  logic                  mem_we;
  logic [MEM_AW-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  p_valid, p_addr, p_wdata, f_valid, f_addr, f_flush, d_valid, d_addr, mem_rdata,
    output p_ready, f_ready, f_rsp_valid, f_rsp_data, d_ready, d_rsp_valid, d_rsp_data,
           d_rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output p_valid, p_addr, p_wdata, f_valid, f_addr, f_flush, d_valid, d_addr, mem_rdata,
    input  p_ready, f_ready, f_rsp_valid, f_rsp_data, d_ready, d_rsp_valid, d_rsp_data,
           d_rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_arb_prio.sv
// Three-way fixed priority P > F > D with an anti-starvation override for D.
// Owns the count of consecutive cycles D has lost to F.
module instr_arb_prio #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p_valid,
  input  logic f_valid,
  input  logic d_valid,
  output logic p_gnt_c,
  output logic f_gnt_c,
  output logic d_gnt_c
);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             starved_c;

  // Grant select; nothing is granted while reset is asserted
  always_comb begin
    p_gnt_c   = 1'b0;
    f_gnt_c   = 1'b0;
    d_gnt_c   = 1'b0;
    starved_c = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    if (rst_n) begin
      if (p_valid)                    p_gnt_c = 1'b1;
      else if (d_valid && starved_c)  d_gnt_c = 1'b1;
      else if (f_valid)               f_gnt_c = 1'b1;
      else if (d_valid)               d_gnt_c = 1'b1;
    end
  end

  // Count only F wins over a waiting D; a P win leaves the count alone
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!d_valid || d_gnt_c) begin
      starve_cnt_d = '0;
    end else if (f_gnt_c && !starved_c) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/instr_mem_arbiter.sv
// Single-port instruction RAM arbiter for program writes, fetches and data loads.
// One access per cycle; reads answer exactly one cycle later, in order.
module instr_mem_arbiter
  import instr_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned MEM_SIZE     = 512,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_mem_arbiter_if.slave bus
);
  localparam int unsigned MEM_AW = mem_aw(MEM_SIZE);

  logic      p_gnt_c, f_gnt_c, d_gnt_c;
  logic      p_bad_c, d_bad_c;
  rsp_pipe_t rsp_q, rsp_d;

  instr_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk     (clk),
    .rst_n   (rst_n),
    .p_valid (bus.p_valid),
    .f_valid (bus.f_valid),
    .d_valid (bus.d_valid),
    .p_gnt_c (p_gnt_c),
    .f_gnt_c (f_gnt_c),
    .d_gnt_c (d_gnt_c)
  );

  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] addr);
    return (addr[1:0] != 2'b00) || ((addr >> (MEM_AW + 2)) != '0);
  endfunction

  // RAM port steering and launch of the response tag
  always_comb begin
    p_bad_c       = addr_bad(bus.p_addr);
    d_bad_c       = addr_bad(bus.d_addr);
    bus.p_ready   = p_gnt_c;
    bus.f_ready   = f_gnt_c;
    bus.d_ready   = d_gnt_c;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = bus.p_wdata;
    rsp_d         = '{tag: TAG_NONE, err: 1'b0};
    if (p_gnt_c) begin
      bus.mem_en   = !p_bad_c;
      bus.mem_we   = !p_bad_c;
      bus.mem_addr = MEM_AW'(bus.p_addr >> 2);
    end else if (f_gnt_c) begin
      // Fetch addresses wrap silently onto the low word bits
      bus.mem_en   = 1'b1;
      bus.mem_addr = MEM_AW'(bus.f_addr >> 2);
      rsp_d        = '{tag: TAG_F, err: 1'b0};
    end else if (d_gnt_c) begin
      bus.mem_en   = !d_bad_c;
      bus.mem_addr = MEM_AW'(bus.d_addr >> 2);
      rsp_d        = '{tag: TAG_D, err: d_bad_c};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_q <= '{tag: TAG_NONE, err: 1'b0};
    else        rsp_q <= rsp_d;
  end

  // Response decode; a flush kills only the fetch response landing this cycle
  always_comb begin
    bus.f_rsp_valid = (rsp_q.tag == TAG_F) && !bus.f_flush;
    bus.f_rsp_data  = bus.f_rsp_valid ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
    bus.d_rsp_valid = (rsp_q.tag == TAG_D);
    bus.d_rsp_err   = bus.d_rsp_valid && rsp_q.err;
    bus.d_rsp_data  = (bus.d_rsp_valid && !rsp_q.err) ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
  end

endmodule
